// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, per-length
// schedule sizes, the forward S-box and GF(2^8) doubling.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;

  // Largest schedule (AES-256) in 32-bit words.
  localparam int NW_MAX = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_SUB
  } state_e;

  // Forward S-box, entry 0x00 in the top byte and entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  nk_of = 4'd6;
      KL_256:  nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  // Number of rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  // Total schedule length in 32-bit words.
  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    case (kl)
      KL_192:  nw_of = 6'd52;
      KL_256:  nw_of = 6'd60;
      default: nw_of = 6'd44;
    endcase
  endfunction

  // Table index (255-b)*8 is simply {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // A key length is usable only if it is encodable and enabled in the build.
  function automatic logic mode_ok(input logic [1:0] kl, input logic [2:0] modes);
    mode_ok = (kl != KL_BAD) && modes[kl];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, optionally registered to
// shorten the combinational path through the key schedule.
module aes_subword
  import aes_pkg::*;
#(
  parameter int SBOX_REG = 0
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  logic [31:0] sub_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign sub_d[gi*8 +: 8] = sbox(word_i[gi*8 +: 8]);
  end

  if (SBOX_REG != 0) begin : g_reg
    logic [31:0] sub_q;

    // Capture the substituted word; wiped with the rest of the key material.
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        sub_q <= '0;
      end else begin
        sub_q <= sub_d;
      end
    end

    assign word_o = sub_q;
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, srst_i};
    assign word_o    = sub_d;
  end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key expansion: loads the cipher key, then generates one
// schedule word per step into a 60-word register file that is read back
// as 128-bit round keys.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int         SBOX_REG = 0,
  parameter logic [2:0] MODES    = 3'b111
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic         zeroize,
  input  logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  output logic [3:0]   nr,
  output logic [127:0] rk_out
);

  state_e      state_q;
  logic [31:0] w_q [NW_MAX];
  logic [5:0]  i_q;
  logic [2:0]  pos_q;       // i mod Nk, tracked incrementally
  logic [1:0]  kl_q;
  logic [7:0]  rcon_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        key_valid_q;
  logic [3:0]  nr_q;

  logic [3:0]  nk_cur;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic        rot_step;
  logic        sub_step;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_d;
  logic [31:0] word_d;
  logic        last_word;
  logic        commit;

  // Next schedule word w[i] from w[i-1] and w[i-Nk].
  always_comb begin
    nk_cur    = nk_of(kl_q);
    w_prev    = w_q[i_q - 6'd1];
    w_back    = w_q[i_q - {2'b00, nk_cur}];
    rot_step  = (pos_q == 3'd0);
    sub_step  = rot_step || ((nk_cur == 4'd8) && (pos_q == 3'd4));
    sub_in    = rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (rot_step) begin
      temp_d = sub_out ^ {rcon_q, 24'h0};
    end else if (sub_step) begin
      temp_d = sub_out;
    end else begin
      temp_d = w_prev;
    end
    word_d    = w_back ^ temp_d;
    last_word = (i_q == nw_of(kl_q) - 6'd1);
    // With a registered S-box, SubWord words are written from SUB instead.
    commit    = ((state_q == ST_EXPAND) && !((SBOX_REG != 0) && sub_step)) ||
                (state_q == ST_SUB);
  end

  aes_subword #(
    .SBOX_REG (SBOX_REG)
  ) u_subword (
    .clk_i  (sys_clk),
    .srst_i (rst | zeroize),
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Control FSM and word storage; reset and zeroize wipe everything.
  always_ff @(posedge sys_clk) begin
    done_q <= 1'b0;
    err_q  <= 1'b0;
    if (rst || zeroize) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      nr_q        <= 4'd0;
      rcon_q      <= 8'h00;
      i_q         <= 6'd0;
      pos_q       <= 3'd0;
      kl_q        <= KL_128;
      for (int j = 0; j < NW_MAX; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mode_ok(key_len, MODES)) begin
              for (int j = 0; j < 8; j++) begin
                if (j < int'(nk_of(key_len))) begin
                  w_q[j] <= key_in[255 - 32*j -: 32];
                end
              end
              state_q     <= ST_EXPAND;
              busy_q      <= 1'b1;
              key_valid_q <= 1'b0;
              nr_q        <= 4'd0;
              rcon_q      <= 8'h01;
              i_q         <= {2'b00, nk_of(key_len)};
              pos_q       <= 3'd0;
              kl_q        <= key_len;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_EXPAND: begin
          if (!commit) begin
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (commit) begin
        w_q[i_q] <= word_d;
        if (rot_step) begin
          rcon_q <= xtime(rcon_q);
        end
        if (last_word) begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          key_valid_q <= 1'b1;
          nr_q        <= nr_of(kl_q);
        end else begin
          state_q <= ST_EXPAND;
          i_q     <= i_q + 6'd1;
          pos_q   <= ({1'b0, pos_q} == nk_cur - 4'd1) ? 3'd0 : pos_q + 3'd1;
        end
      end
    end
  end

  // Round-key readout, masked unless a complete schedule covers the index.
  always_comb begin
    rk_out = '0;
    if (key_valid_q && (rk_idx <= nr_q)) begin
      rk_out = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign nr        = nr_q;

endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 Parameter SBOX_REG, default 0, meaning: 1 = register the S-box output, adding one cycle per SubWord step.
REQ-002 Parameter MODES, default 3'b111, meaning: bit0/1/2 enable AES-128/192/256 support respectively.
REQ-003 sys_clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request expansion of key_in under key_len; sampled only in IDLE.
REQ-006 key_len  in  2  00=128, 01=192, 10=256, 11=invalid.
REQ-007 key_in  in  256  cipher key, MSB-aligned; unused low bits ignored (128: [255:128], 192: [255:64]).
REQ-008 zeroize  in  1  wipe all key material and abort any expansion.
REQ-009 rk_idx  in  4  round-key read index 0..14.
REQ-010 busy  out  1  expansion in progress.
REQ-011 done  out  1  one-cycle pulse when the schedule is complete.
REQ-012 key_valid  out  1  stored schedule is complete and readable.
REQ-013 err  out  1  one-cycle pulse on a rejected start.
REQ-014 nr  out  4  round count of the stored schedule (10/12/14), 0 when not valid.
REQ-015 rk_out  out  128  combinational {w[4k],w[4k+1],w[4k+2],w[4k+3]} for k=rk_idx.

Function
REQ-016 Nk/Nr/Nw SHALL be 4/10/44, 6/12/52, 8/14/60 for 128/192/256.
REQ-017 The FSM SHALL have states IDLE, EXPAND, SUB (SUB only when SBOX_REG=1).
REQ-018 Start accept (IDLE, start=1, valid mode): write w[0..Nk-1] from key_in, clear key_valid, set rcon=0x01 and i=Nk, go to EXPAND.
REQ-019 EXPAND SHALL write one word per cycle: w[i]=w[i-Nk]^temp, where temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0} if i mod Nk==0, SubWord(w[i-1]) if Nk==8 and i mod 8==4, else w[i-1].
REQ-020 rcon SHALL advance by GF(2^8) xtime after each i mod Nk==0 word (0x80 -> 0x1B).
REQ-021 With SBOX_REG=1, each SubWord word SHALL take two cycles (EXPAND->SUB->EXPAND), writing in SUB.
REQ-022 When w[Nw-1] is written: go to IDLE, pulse done, set key_valid=1 and nr=Nr on the same edge.
REQ-023 Cycles from the accept edge to done high SHALL be 40/46/52 (SBOX_REG=0) and 50/54/65 (SBOX_REG=1).
REQ-024 busy SHALL be high in every cycle between the accept edge and the done cycle, exclusive of the done cycle.
REQ-025 start while busy SHALL be ignored, with no err.
REQ-026 start with key_len=11 or a disabled mode SHALL pulse err, stay IDLE and leave the stored schedule and key_valid unchanged.
REQ-027 rk_out SHALL be zero when key_valid=0 or rk_idx>nr.
REQ-028 zeroize SHALL take priority over start. On the next edge it SHALL clear all words, key_valid, nr and rcon, go to IDLE and suppress done.

Reset
REQ-029 rst SHALL have priority over all inputs.
REQ-030 On rst all 60 words SHALL be zero and state SHALL be IDLE.
REQ-031 On rst busy, done, err, key_valid and nr SHALL be 0, and hence rk_out SHALL be 0.
REQ-032 rst mid-expansion SHALL abort identically to zeroize.

Structure
REQ-033 Package aes_pkg SHALL hold the key_len encodings, the Nk/Nr/Nw lookup functions, the S-box table function and the xtime function.
REQ-034 Sub-module aes_subword SHALL apply four parallel S-box lookups, with an output register when SBOX_REG=1.
REQ-035 Word storage SHALL be a 60x32 register array.
REQ-036 Exactly one aes_subword instance SHALL exist.

Verification
REQ-037 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> done 40 cycles after accept; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; nr=10.
REQ-038 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx=12 gives e98ba06f448c773c8ecc720401002202; done at 46 (54 with SBOX_REG=1).
REQ-039 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx=14 gives fe4890d1e6188d0b046df344706c631e; rk_idx=15 gives 0.
REQ-040 zeroize at cycle 20 of a 256 run -> busy drops next cycle, no done, key_valid=0, all rk_idx give 0; a following 128 start completes correctly.
REQ-041 start with key_len=11 after a valid 128 schedule -> err one cycle, key_valid stays 1, rk_out unchanged; start during busy -> ignored.
REQ-042 rst asserted at cycle 10 of a 192 run -> all outputs 0 next cycle, state IDLE.
